// File: rtl/v1_queue_ctrl.sv
// v1_queue_ctrl: control unit for the v1 shift-register FIFO.
//
// Owns the enqueue/dequeue val/rdy handshakes and the occupancy count. It
// drives the per-slot write strobes and shift enables of an external
// p_depth-slot register collection and presents the head entry (slot
// p_depth-1) on the dequeue port. With occupancy n, entries sit in slots
// p_depth-n .. p_depth-1. On a shift, slot i loads slot i-1.
//
// Optional feature: define V1_QUEUE_CTRL_BYPASS_EN to offer an entry to the
// consumer in the same cycle it arrives at an empty queue. Without the
// macro, empty-queue latency is one cycle and deq_val never looks at enq_val.
//
// Handshake: a transfer happens on a port in a cycle where both its val and
// its rdy are high at the rising clock edge. enq_rdy does not depend on
// enq_val, and deq_val (bypass disabled) does not depend on deq_rdy. While
// rst is high, enq_rdy and deq_val are both low, so nothing transfers.

module v1_queue_ctrl #(
  parameter int p_depth    = 32,
  parameter int p_idwidth  = $clog2(p_depth),
  parameter int p_cntwidth = $clog2(p_depth + 1),
  parameter int p_bitwidth = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_val,
  output logic                  enq_rdy,
  input  logic [p_bitwidth-1:0] enq_msg,
  output logic                  deq_val,
  input  logic                  deq_rdy,
  output logic [p_bitwidth-1:0] deq_msg,
  output logic [p_depth-1:0]    wr_data,
  output logic [p_bitwidth-1:0] wr_data_in,
  output logic [p_depth-1:0]    shift_en,
  input  logic [p_bitwidth-1:0] data_in [p_depth],
  output logic [p_cntwidth-1:0] count
);

  logic                 empty;
  logic                 full;
  logic                 enq_fire;
  logic                 deq_fire;
  logic                 enq_only;
  logic                 enq_deq;
  logic [p_idwidth-1:0] wr_idx;
  logic                 data_in_unused;

  // Occupancy flags straight from the count register.
  always_comb begin
    empty = (count == '0);
    full  = (count == p_cntwidth'(p_depth));
  end

  // Ready/valid and head presentation; both sides are held off during reset.
  always_comb begin
    enq_rdy = !rst && !full;
`ifdef V1_QUEUE_CTRL_BYPASS_EN
    // An empty queue forwards the incoming entry straight to the consumer.
    deq_val = !rst && (!empty || enq_val);
    deq_msg = empty ? enq_msg : data_in[p_depth-1];
`else
    deq_val = !rst && !empty;
    deq_msg = data_in[p_depth-1];
`endif
  end

  // Fire decode. enq_deq excludes the empty case so a bypassed entry
  // (only possible with the bypass feature) never writes a slot.
  always_comb begin
    enq_fire = enq_val && enq_rdy;
    deq_fire = deq_val && deq_rdy;
    enq_only = enq_fire && !deq_fire;
    enq_deq  = enq_fire && deq_fire && !empty;
  end

  // Write slot: the free slot just below the tail (p_depth-1-n) on a plain
  // enqueue, or the tail slot itself (p_depth-n) when the tail is shifting up
  // in the same cycle. Count is never p_depth when a write happens.
  always_comb begin
    wr_idx = p_idwidth'(p_depth - 1) - count[p_idwidth-1:0]
             + p_idwidth'(enq_deq);
  end

  // Per-slot strobes. A dequeue shifts every occupied slot except the tail up
  // by one; the write target is never one of the shifted slots.
  always_comb begin
    wr_data  = '0;
    shift_en = '0;
    if (enq_only || enq_deq) begin
      wr_data[wr_idx] = 1'b1;
    end
    if (deq_fire) begin
      for (int i = 1; i < p_depth; i++) begin
        if (i >= p_depth - int'(count) + 1) begin
          shift_en[i] = 1'b1;
        end
      end
    end
  end

  // Storage write data is the producer's entry, unconditionally.
  always_comb begin
    wr_data_in = enq_msg;
  end

  // Only the head slot is read; the remaining slot contents are not needed.
  always_comb begin
    data_in_unused = 1'b0;
    for (int i = 0; i < p_depth - 1; i++) begin
      data_in_unused = data_in_unused ^ (^data_in[i]);
    end
  end

  // Occupancy count: +1 on enqueue only, -1 on dequeue only, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enq_fire && !deq_fire) begin
      count <= count + p_cntwidth'(1);
    end else if (deq_fire && !enq_fire) begin
      count <= count - p_cntwidth'(1);
    end
  end

endmodule

// File: tb/tb_v1_queue_ctrl.sv
// tb_v1_queue_ctrl: directed bench for v1_queue_ctrl with p_depth=4,
// p_bitwidth=32. A small shift-register storage model stands in for the
// register collection. Build with V1_QUEUE_CTRL_BYPASS_EN defined to check
// the bypass variant.

module tb_v1_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int BW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          enq_val;
  logic          enq_rdy;
  logic [BW-1:0] enq_msg;
  logic          deq_val;
  logic          deq_rdy;
  logic [BW-1:0] deq_msg;
  logic [DEPTH-1:0] wr_data;
  logic [BW-1:0] wr_data_in;
  logic [DEPTH-1:0] shift_en;
  logic [BW-1:0] slot [DEPTH];
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  v1_queue_ctrl #(
    .p_depth   (DEPTH),
    .p_bitwidth(BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_val   (enq_val),
    .enq_rdy   (enq_rdy),
    .enq_msg   (enq_msg),
    .deq_val   (deq_val),
    .deq_rdy   (deq_rdy),
    .deq_msg   (deq_msg),
    .wr_data   (wr_data),
    .wr_data_in(wr_data_in),
    .shift_en  (shift_en),
    .data_in   (slot),
    .count     (count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: write strobe loads wr_data_in, shift loads the slot below.
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_data[i]) slot[i] <= wr_data_in;
      else if (shift_en[i] && i > 0) slot[i] <= slot[i-1];
    end
  end

  // Slot exclusivity every cycle.
  always @(negedge clk) begin
    n_checks++;
    assert ((wr_data & shift_en) === '0) else begin
      n_fail++;
      $error("FAIL excl observed=%b/%b expected=no overlap", wr_data, shift_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [3:0] exp_wr_fill [4];
    logic [3:0] exp_sh_drain [4];
    exp_wr_fill  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    exp_sh_drain = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < DEPTH; i++) slot[i] = '0;

    // Reset held two cycles with enq_val high
    rst = 1'b1; enq_val = 1'b1; enq_msg = 32'h11; deq_rdy = 1'b0;
    tick();
    settle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_enq_rdy", 32'(enq_rdy), 32'd0);
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_shift_en", 32'(shift_en), 32'd0);
    tick();
    rst = 1'b0; enq_val = 1'b0;
    settle();
    chk("post_rst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("post_rst_count", 32'(count), 32'd0);

    // Fill 0xA0..0xA3
    for (int k = 0; k < 4; k++) begin
      enq_val = 1'b1; enq_msg = 32'hA0 + 32'(k);
      settle();
      chk("fill_wr_data", 32'(wr_data), 32'(exp_wr_fill[k]));
      chk("fill_shift_en", 32'(shift_en), 32'd0);
      chk("fill_wr_data_in", wr_data_in, 32'hA0 + 32'(k));
      tick();
    end
    enq_val = 1'b1; enq_msg = 32'hA4;
    settle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_enq_rdy", 32'(enq_rdy), 32'd0);
    chk("full_wr_data", 32'(wr_data), 32'd0);
    tick();
    enq_val = 1'b0;
    settle();
    chk("full_hold_count", 32'(count), 32'd4);

    // Drain in order
    for (int k = 0; k < 4; k++) begin
      deq_rdy = 1'b1;
      settle();
      chk("drain_deq_val", 32'(deq_val), 32'd1);
      chk("drain_deq_msg", deq_msg, 32'hA0 + 32'(k));
      chk("drain_shift_en", 32'(shift_en), 32'(exp_sh_drain[k]));
      tick();
    end
    settle();
    chk("drained_deq_val", 32'(deq_val), 32'd0);
    chk("drained_shift_en", 32'(shift_en), 32'd0);
    tick();
    chk("empty_deq_count", 32'(count), 32'd0);
    deq_rdy = 1'b0;

    // Simultaneous enqueue/dequeue at count 2
    enq_val = 1'b1; enq_msg = 32'hB0; tick();
    enq_msg = 32'hB1; tick();
    deq_rdy = 1'b1;
    enq_msg = 32'hC0; settle();
    chk("sim0_count", 32'(count), 32'd2);
    chk("sim0_deq_msg", deq_msg, 32'hB0);
    chk("sim0_wr_data", 32'(wr_data), 32'b0100);
    chk("sim0_shift_en", 32'(shift_en), 32'b1000);
    tick();
    enq_msg = 32'hC1; settle();
    chk("sim1_count", 32'(count), 32'd2);
    chk("sim1_deq_msg", deq_msg, 32'hB1);
    tick();
    enq_msg = 32'hC2; settle();
    chk("sim2_count", 32'(count), 32'd2);
    chk("sim2_deq_msg", deq_msg, 32'hC0);
    tick();
    chk("sim_end_count", 32'(count), 32'd2);

    // Fill to full (C1, C2, F0, F1), then dequeue while full
    deq_rdy = 1'b0;
    enq_msg = 32'hF0; tick();
    enq_msg = 32'hF1; tick();
    enq_msg = 32'hF2; deq_rdy = 1'b1;
    settle();
    chk("fulldq_enq_rdy", 32'(enq_rdy), 32'd0);
    chk("fulldq_deq_msg", deq_msg, 32'hC1);
    chk("fulldq_wr_data", 32'(wr_data), 32'd0);
    chk("fulldq_shift_en", 32'(shift_en), 32'b1110);
    tick();
    settle();
    chk("fulldq_count", 32'(count), 32'd3);
    chk("fulldq_enq_rdy_next", 32'(enq_rdy), 32'd1);
    chk("fulldq_deq_msg_next", deq_msg, 32'hC2);
    chk("fulldq_wr_next", 32'(wr_data), 32'b0010);
    chk("fulldq_shift_next", 32'(shift_en), 32'b1100);
    tick();
    chk("fulldq_count_next", 32'(count), 32'd3);
    enq_val = 1'b0; deq_rdy = 1'b0;

    // Mid-operation reset
    rst = 1'b1; tick();
    rst = 1'b0; settle();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_deq_val", 32'(deq_val), 32'd0);
    enq_val = 1'b1; enq_msg = 32'hD0; tick();
    enq_val = 1'b0; deq_rdy = 1'b1; settle();
    chk("midrst_d0_val", 32'(deq_val), 32'd1);
    chk("midrst_d0_msg", deq_msg, 32'hD0);
    tick();
    chk("midrst_d0_count", 32'(count), 32'd0);

    // Empty queue, enq_val and deq_rdy together
    enq_val = 1'b1; deq_rdy = 1'b1; enq_msg = 32'hE5;
    settle();
`ifdef V1_QUEUE_CTRL_BYPASS_EN
    chk("byp_deq_val", 32'(deq_val), 32'd1);
    chk("byp_deq_msg", deq_msg, 32'hE5);
    chk("byp_wr_data", 32'(wr_data), 32'd0);
    tick();
    chk("byp_count", 32'(count), 32'd0);
    enq_val = 1'b0; deq_rdy = 1'b0;
`else
    chk("nobyp_deq_val", 32'(deq_val), 32'd0);
    chk("nobyp_wr_data", 32'(wr_data), 32'b1000);
    tick();
    chk("nobyp_count", 32'(count), 32'd1);
    enq_val = 1'b0; settle();
    chk("nobyp_deq_msg", deq_msg, 32'hE5);
    tick();
    deq_rdy = 1'b0;
    chk("nobyp_count_end", 32'(count), 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v1_queue_ctrl.md
# v1_queue_ctrl

Control unit for the v1 shift-register FIFO. It owns the enqueue/dequeue val/rdy handshakes and the occupancy count. Each cycle it drives the per-slot write strobes and shift enables of the register collection, and presents the head entry on the dequeue port. It sits between the producer/consumer interfaces and the storage array, which it treats as `p_depth` slots. On a shift, slot i loads slot i-1.

## Interface
- `p_depth`, 32, number of storage slots; must be ≥ 2
- `p_idwidth`, `$clog2(p_depth)`, slot index width
- `p_cntwidth`, `$clog2(p_depth+1)`, occupancy count width (holds 0..`p_depth`)
- `p_bitwidth`, 32, entry width
- `clk` input 1: clock; single clock domain
- `rst` input 1: reset, synchronous, active-high
- `enq_val` input 1: producer has a valid entry
- `enq_rdy` output 1: controller accepts an entry this cycle
- `enq_msg` input `p_bitwidth`: entry to enqueue
- `deq_val` output 1: head entry valid
- `deq_rdy` input 1: consumer takes the head this cycle
- `deq_msg` output `p_bitwidth`: head entry
- `wr_data` output 1 × [`p_depth`]: per-slot write strobe to storage
- `wr_data_in` output `p_bitwidth`: write data to storage; always equals `enq_msg`
- `shift_en` output 1 × [`p_depth`]: per-slot shift enable to storage
- `data_in` input `p_bitwidth` × [`p_depth`]: storage slot contents
- `count` output `p_cntwidth`: current occupancy

## Operation
- **Occupancy layout:** entries with occupancy n sit in slots `p_depth-n` .. `p_depth-1`.
  - Head is slot `p_depth-1`; tail is slot `p_depth-n`.
- **Flags:** `empty` = (`count`==0); `full` = (`count`==`p_depth`). Both are combinational from the `count` register.
- **Ready/valid:**
  - `enq_rdy` = !`full`. There is no enqueue-through-full, even when `deq_rdy` is high.
  - `deq_val` = !`empty`.
  - `deq_msg` = `data_in[p_depth-1]`.
- **Fire signals:** `enq_fire` = `enq_val` & `enq_rdy`; `deq_fire` = `deq_val` & `deq_rdy`.
- **Enqueue only (n = `count`):** assert `wr_data[p_depth-1-n]`; no shifts; `count` += 1.
- **Dequeue only:** assert `shift_en[i]` for every i with `p_depth-n+1` ≤ i ≤ `p_depth-1`; `count` -= 1.
  - When n==1, no slot shifts; the head slot becomes stale and is ignored.
- **Enqueue and dequeue together:**
  - Shift enables are the same as for dequeue only.
  - Assert `wr_data[p_depth-n]`.
  - `count` is unchanged.
  - When n==1, this writes the head slot directly.
- **Slot exclusivity:** no slot ever has `wr_data` and `shift_en` asserted together. The verification bench asserts this every cycle.
- **Idle:** all strobes and enables low.
- **Arithmetic:** `count` is unsigned. Increment and decrement are guarded by `full`/`empty`, so the count never wraps.

## Timing
- **Reset:**
  - While `rst` is high, all strobes and enables are forced to 0.
  - While `rst` is high, `enq_rdy`=0 and `deq_val`=0.
  - `count` loads 0 at the clock edge where `rst` is high.
  - Reset asserted mid-operation discards all entries; storage contents become don't-care.
- **Strobe timing:** `wr_data` and `shift_en` are combinational in the same cycle as the fire. Storage updates at that clock edge.
- **Latency:** an entry enqueued in cycle t appears at `deq_msg` with `deq_val`=1 in cycle t+1 at the earliest, when the queue was empty.
- **Throughput:** one enqueue plus one dequeue per cycle when not full and not empty.
- **Full:** `deq_fire` in a full cycle frees a slot; `enq_rdy` rises the next cycle.
- **Empty:** a dequeue attempt has no effect; `deq_rdy` is ignored.

## Configuration
- **`V1_QUEUE_CTRL_BYPASS_EN` defined:** when `count`==0 and `enq_val`=1, the entry is offered to the consumer in the same cycle.
  - `deq_val`=1 and `deq_msg`=`enq_msg`.
  - If `deq_rdy`=1: no slot is written and `count` stays 0. This gives zero-cycle latency.
  - If `deq_rdy`=0: a normal enqueue occurs.
- **`V1_QUEUE_CTRL_BYPASS_EN` undefined:** empty-queue latency is 1 cycle, as in Timing. `deq_val` never depends on `enq_val`.

## Test plan
All scenarios use `p_depth`=4 and `p_bitwidth`=32.
- **Reset:** hold `rst` for 2 cycles with `enq_val`=1.
  - During reset: `count`=0, `enq_rdy`=0, `deq_val`=0, all strobes 0.
  - After reset: `enq_rdy`=1.
- **Fill then drain:**
  - Enqueue 0xA0..0xA3. `wr_data` index sequence is 3,2,1,0. `count` reaches 4 and `enq_rdy`=0.
  - A fifth `enq_val` is not accepted.
  - Dequeue 4 entries in order 0xA0..0xA3. `deq_val`=0 afterwards.
- **Simultaneous enqueue and dequeue:** with `count`=2 holding 0xB0,0xB1, assert both fires for 3 cycles with 0xC0..0xC2.
  - `count` stays 2 throughout.
  - Output order is 0xB0,0xB1,0xC0.
  - Slot exclusivity holds every cycle.
- **Full with dequeue:** with the queue full, `enq_val`=1 and `deq_rdy`=1.
  - Only the dequeue fires and `count`=3.
  - The enqueue is accepted on the next cycle.
- **Mid-operation reset:** reset with `count`=3 → `count`=0 and `deq_val`=0 next cycle. Then enqueue 0xD0 → dequeued as 0xD0.
- **Bypass (macro defined):** with the queue empty, `enq_val`=`deq_rdy`=1 and `enq_msg`=0xE5.
  - Same cycle: `deq_val`=1, `deq_msg`=0xE5, no `wr_data` strobe, `count` stays 0.
  - With the macro undefined, the same stimulus gives `deq_val`=0 that cycle and `count`=1 after.
